sdram_inport_arbiter: RTL and testbench

Two-requester arbiter that shares the single-word inport of the SDRAM AXI core between two independent masters. It sits directly in front of the core, sees both requesters, and grants the inport round-robin. It records the owner of every accepted request in an ordering FIFO, so that in-order acks, errors and read data are routed back to the correct requester.

---
 rtl/sdram_inport_arbiter.sv | 242 ++++++++++++++++++++++++
 tb/tb_sdram_inport_arbiter.sv | 483 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_inport_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_inport_arbiter
// Purpose  : Shares the single-word request inport of the SDRAM AXI core
//            between two independent requesters. Grants are issued
//            round-robin through a small grant FSM. The owner of every
//            accepted request is recorded in an ordering FIFO so that the
//            core's in-order acks, errors and read data are steered back to
//            the requester that issued the request.
// Ports    : clk_i / rst_i                - clock, synchronous active-high reset
//            req{0,1}_*_i                 - request fields from each requester
//            req{0,1}_accept/ack/error_o  - per-requester handshake/response
//            req{0,1}_read_data_o         - read data, valid with ack
//            inport_*_o                   - muxed request towards the core
//            inport_accept/ack/error_i,
//            inport_read_data_i           - core handshake and response
//            spurious_ack_o               - sticky: ack seen with FIFO empty
// Revision : 1.0 - initial release
// ============================================================================
module sdram_inport_arbiter #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic [3:0]  req0_wr_i,
    input  logic        req0_rd_i,
    input  logic [7:0]  req0_len_i,
    input  logic [31:0] req0_addr_i,
    input  logic [31:0] req0_write_data_i,
    output logic        req0_accept_o,
    output logic        req0_ack_o,
    output logic        req0_error_o,
    output logic [31:0] req0_read_data_o,

    input  logic [3:0]  req1_wr_i,
    input  logic        req1_rd_i,
    input  logic [7:0]  req1_len_i,
    input  logic [31:0] req1_addr_i,
    input  logic [31:0] req1_write_data_i,
    output logic        req1_accept_o,
    output logic        req1_ack_o,
    output logic        req1_error_o,
    output logic [31:0] req1_read_data_o,

    output logic [3:0]  inport_wr_o,
    output logic        inport_rd_o,
    output logic [7:0]  inport_len_o,
    output logic [31:0] inport_addr_o,
    output logic [31:0] inport_write_data_o,
    input  logic        inport_accept_i,
    input  logic        inport_ack_i,
    input  logic        inport_error_i,
    input  logic [31:0] inport_read_data_i,

    output logic        spurious_ack_o
);

    localparam int              PTR_W      = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]  FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              prio;
    logic              prio_next;

    logic              req0_valid;
    logic              req1_valid;

    logic              push;
    logic              push_id;
    logic              pop;
    logic              head;
    logic              fifo_full;
    logic              fifo_empty;

    logic              owner_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              spurious;

    assign req0_valid = (|req0_wr_i) | req0_rd_i;
    assign req1_valid = (|req1_wr_i) | req1_rd_i;

    assign fifo_full  = (count == FULL_COUNT);
    assign fifo_empty = (count == '0);
    assign head       = owner_mem[rd_ptr];

    // ------------------------------------------------------------------
    // Grant FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            prio  <= 1'b0;
        end else begin
            state <= state_next;
            prio  <= prio_next;
        end
    end

    always_comb begin
        state_next = state;
        prio_next  = prio;
        push       = 1'b0;
        push_id    = 1'b0;
        case (state)
            IDLE: begin
                // A full FIFO blocks new grants; an ack popping in this
                // same cycle only frees the slot for the next decision.
                if (!fifo_full) begin
                    if (req0_valid && req1_valid) begin
                        state_next = prio ? GRANT1 : GRANT0;
                    end else if (req0_valid) begin
                        state_next = GRANT0;
                    end else if (req1_valid) begin
                        state_next = GRANT1;
                    end
                end
            end
            GRANT0: begin
                if (inport_accept_i) begin
                    push       = 1'b1;
                    push_id    = 1'b0;
                    prio_next  = 1'b1;
                    state_next = IDLE;
                end else if (!req0_valid) begin
                    // Requester withdrew before acceptance: drop the grant.
                    state_next = IDLE;
                end
            end
            GRANT1: begin
                if (inport_accept_i) begin
                    push       = 1'b1;
                    push_id    = 1'b1;
                    prio_next  = 1'b0;
                    state_next = IDLE;
                end else if (!req1_valid) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request mux towards the core. Fields are forced to zero when no
    // grant is active so the inport is quiet outside a grant.
    // ------------------------------------------------------------------
    always_comb begin
        inport_wr_o         = 4'd0;
        inport_rd_o         = 1'b0;
        inport_len_o        = 8'd0;
        inport_addr_o       = 32'd0;
        inport_write_data_o = 32'd0;
        if (!rst_i) begin
            case (state)
                GRANT0: begin
                    inport_wr_o         = req0_wr_i;
                    inport_rd_o         = req0_rd_i;
                    inport_len_o        = req0_len_i;
                    inport_addr_o       = req0_addr_i;
                    inport_write_data_o = req0_write_data_i;
                end
                GRANT1: begin
                    inport_wr_o         = req1_wr_i;
                    inport_rd_o         = req1_rd_i;
                    inport_len_o        = req1_len_i;
                    inport_addr_o       = req1_addr_i;
                    inport_write_data_o = req1_write_data_i;
                end
                default: begin
                end
            endcase
        end
    end

    assign req0_accept_o = ~rst_i & (state == GRANT0) & inport_accept_i;
    assign req1_accept_o = ~rst_i & (state == GRANT1) & inport_accept_i;

    // ------------------------------------------------------------------
    // Ordering FIFO of 1-bit owner IDs
    // ------------------------------------------------------------------
    assign pop = inport_ack_i & ~fifo_empty & ~rst_i;

    always_ff @(posedge clk_i) begin
        if (push && !rst_i) begin
            owner_mem[wr_ptr] <= push_id;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Response routing: the head of the FIFO owns the current ack.
    // ------------------------------------------------------------------
    assign req0_ack_o       = pop & ~head;
    assign req1_ack_o       = pop &  head;
    assign req0_error_o     = req0_ack_o & inport_error_i;
    assign req1_error_o     = req1_ack_o & inport_error_i;
    assign req0_read_data_o = {32{req0_ack_o}} & inport_read_data_i;
    assign req1_read_data_o = {32{req1_ack_o}} & inport_read_data_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            spurious <= 1'b0;
        end else if (inport_ack_i && fifo_empty) begin
            spurious <= 1'b1;
        end
    end

    assign spurious_ack_o = spurious & ~rst_i;

endmodule
`default_nettype wire

// File: tb/tb_sdram_inport_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_inport_arbiter
// Purpose  : Self-checking bench for sdram_inport_arbiter. Directed
//            scenarios plus a randomized run compared against a queue-based
//            reference model of the arbitration and ordering rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_inport_arbiter;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;

    logic [1:0][3:0]  wr;
    logic [1:0]       rd;
    logic [1:0][7:0]  len;
    logic [1:0][31:0] addr;
    logic [1:0][31:0] wdata;
    logic [1:0]       acc;
    logic [1:0]       ack;
    logic [1:0]       err;
    logic [1:0][31:0] rdata;

    logic [3:0]  in_wr;
    logic        in_rd;
    logic [7:0]  in_len;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic        c_acc;
    logic        c_ack;
    logic        c_err;
    logic [31:0] c_rdata;
    logic        spur;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: current grant (-1 none), round-robin pointer,
    // owner queue and sticky spurious flag.
    int mg = -1;
    int mp = 0;
    int mq[$];
    bit ms = 1'b0;

    always #5 clk = ~clk;

    sdram_inport_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .req0_wr_i           (wr[0]),
        .req0_rd_i           (rd[0]),
        .req0_len_i          (len[0]),
        .req0_addr_i         (addr[0]),
        .req0_write_data_i   (wdata[0]),
        .req0_accept_o       (acc[0]),
        .req0_ack_o          (ack[0]),
        .req0_error_o        (err[0]),
        .req0_read_data_o    (rdata[0]),
        .req1_wr_i           (wr[1]),
        .req1_rd_i           (rd[1]),
        .req1_len_i          (len[1]),
        .req1_addr_i         (addr[1]),
        .req1_write_data_i   (wdata[1]),
        .req1_accept_o       (acc[1]),
        .req1_ack_o          (ack[1]),
        .req1_error_o        (err[1]),
        .req1_read_data_o    (rdata[1]),
        .inport_wr_o         (in_wr),
        .inport_rd_o         (in_rd),
        .inport_len_o        (in_len),
        .inport_addr_o       (in_addr),
        .inport_write_data_o (in_wdata),
        .inport_accept_i     (c_acc),
        .inport_ack_i        (c_ack),
        .inport_error_i      (c_err),
        .inport_read_data_i  (c_rdata),
        .spurious_ack_o      (spur)
    );

    task automatic model_update();
        int  sz;
        bit  v0;
        bit  v1;
        sz = mq.size();
        v0 = (|wr[0]) || rd[0];
        v1 = (|wr[1]) || rd[1];
        if (rst) begin
            mg = -1;
            mp = 0;
            mq.delete();
            ms = 1'b0;
            return;
        end
        if (c_ack) begin
            if (sz > 0) void'(mq.pop_front());
            else        ms = 1'b1;
        end
        if (mg < 0) begin
            if (sz < DEPTH) begin
                if (v0 && v1)  mg = mp;
                else if (v0)   mg = 0;
                else if (v1)   mg = 1;
            end
        end else if (c_acc) begin
            mq.push_back(mg);
            mp = 1 - mg;
            mg = -1;
        end else if (!((mg == 0) ? v0 : v1)) begin
            mg = -1;
        end
    endtask

    // Advance one clock: model follows the edge, return at the next negedge.
    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        wr = '0; rd = '0; len = '0; addr = '0; wdata = '0;
        c_acc = 1'b0; c_ack = 1'b0; c_err = 1'b0; c_rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Issue one read from requester n and have the core accept it.
    task automatic issue(input int n);
        rd[n]   = 1'b1;
        addr[n] = 32'h1000 + 32'(n);
        step();
        c_acc = 1'b1;
        step();
        c_acc = 1'b0;
        rd[n] = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        #1;
        n_checks++;
        if ({in_wr, in_rd, acc, ack, err, spur, in_addr} !== '0) begin
            n_fail++;
            $display("FAIL reset_during: got %h expected 0", {in_wr, in_rd, acc, ack, err, spur, in_addr});
        end
        step();
        rst = 1'b0;
        #1;
        n_checks++;
        if ({in_wr, in_rd, acc, ack, err, spur, in_addr} !== '0) begin
            n_fail++;
            $display("FAIL reset_after: got %h expected 0", {in_wr, in_rd, acc, ack, err, spur, in_addr});
        end
    endtask

    task automatic test_single_read();
        do_reset();
        rd[0] = 1'b1; addr[0] = 32'h100; len[0] = 8'h3;
        step();
        #1;
        n_checks++;
        if ({in_rd, in_addr, in_len} !== {1'b1, 32'h100, 8'h3}) begin
            n_fail++;
            $display("FAIL single_read_present: got rd=%h addr=%h len=%h expected 1/100/03", in_rd, in_addr, in_len);
        end
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (acc !== 2'b00) begin
                n_fail++;
                $display("FAIL single_read_early_accept: got %b expected 00", acc);
            end
            step();
        end
        c_acc = 1'b1;
        #1;
        n_checks++;
        if (acc !== 2'b01) begin
            n_fail++;
            $display("FAIL single_read_accept: got %b expected 01", acc);
        end
        step();
        c_acc = 1'b0; rd[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if ({acc, in_rd, ack} !== 5'b0) begin
                n_fail++;
                $display("FAIL single_read_quiet: got acc=%b rd=%b ack=%b expected 0", acc, in_rd, ack);
            end
            step();
        end
        c_ack = 1'b1; c_rdata = 32'hDEADBEEF;
        #1;
        n_checks++;
        if ({ack, err, rdata[0]} !== {2'b01, 2'b00, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL single_read_ack: got ack=%b err=%b data=%h expected 01/00/deadbeef", ack, err, rdata[0]);
        end
        step();
        c_ack = 1'b0;
        #1;
        n_checks++;
        if (ack !== 2'b00) begin
            n_fail++;
            $display("FAIL single_read_ack_pulse: got %b expected 00", ack);
        end
    endtask

    task automatic test_contention();
        int owner;
        do_reset();
        wr[0] = 4'hF; wr[1] = 4'hF;
        wdata[0] = 32'hA0A0A0A0; wdata[1] = 32'hB1B1B1B1;
        c_acc = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            owner = (i / 2) % 2;
            c_ack = (i % 2 == 1);
            #1;
            n_checks++;
            if (i % 2 == 0) begin
                if ({in_wr, in_wdata, acc} !== {4'hF, wdata[owner], (owner == 0) ? 2'b01 : 2'b10}) begin
                    n_fail++;
                    $display("FAIL contention_grant%0d: got wr=%h data=%h acc=%b owner expected %0d", i, in_wr, in_wdata, acc, owner);
                end
            end else begin
                if ({in_wr, acc, ack} !== {4'h0, 2'b00, (owner == 0) ? 2'b01 : 2'b10}) begin
                    n_fail++;
                    $display("FAIL contention_bubble%0d: got wr=%h acc=%b ack=%b owner expected %0d", i, in_wr, acc, ack, owner);
                end
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        int pulses = 0;
        do_reset();
        rd[0] = 1'b1; c_acc = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (acc[0]) pulses++;
            step();
        end
        n_checks++;
        if (pulses !== DEPTH) begin
            n_fail++;
            $display("FAIL backpressure_accepts: got %0d expected %0d", pulses, DEPTH);
        end
        c_ack = 1'b1;
        #1;
        n_checks++;
        if ({ack, acc, in_rd} !== {2'b01, 2'b00, 1'b0}) begin
            n_fail++;
            $display("FAIL backpressure_ack_cycle: got ack=%b acc=%b rd=%b expected 01/00/0", ack, acc, in_rd);
        end
        step();
        c_ack = 1'b0;
        #1;
        n_checks++;
        if ({acc, in_rd} !== 3'b000) begin
            n_fail++;
            $display("FAIL backpressure_still_blocked: got acc=%b rd=%b expected 00/0", acc, in_rd);
        end
        step();
        #1;
        n_checks++;
        if ({acc, in_rd} !== 3'b011) begin
            n_fail++;
            $display("FAIL backpressure_resume: got acc=%b rd=%b expected 01/1", acc, in_rd);
        end
        step();
        idle_inputs();
    endtask

    task automatic test_ordering();
        int own[3] = '{1, 0, 1};
        do_reset();
        issue(1); issue(0); issue(1);
        for (int k = 0; k < 3; k++) begin
            c_ack = 1'b1; c_err = (k == 1); c_rdata = $urandom;
            #1;
            n_checks++;
            if ({ack, err, rdata[own[k]]} !== {(own[k] == 0) ? 2'b01 : 2'b10,
                                               (k == 1) ? 2'b01 : 2'b00, c_rdata}) begin
                n_fail++;
                $display("FAIL ordering_ack%0d: got ack=%b err=%b data=%h expected owner %0d data %h", k, ack, err, rdata[own[k]], own[k], c_rdata);
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_push_pop();
        int own[3] = '{0, 0, 1};
        do_reset();
        issue(1); issue(0); issue(0);
        rd[1] = 1'b1;
        step();
        c_acc = 1'b1; c_ack = 1'b1;
        #1;
        n_checks++;
        if ({acc, ack} !== 4'b1010) begin
            n_fail++;
            $display("FAIL pushpop_same_cycle: got acc=%b ack=%b expected 10/10", acc, ack);
        end
        step();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            c_ack = 1'b1;
            #1;
            n_checks++;
            if (ack !== ((own[k] == 0) ? 2'b01 : 2'b10)) begin
                n_fail++;
                $display("FAIL pushpop_drain%0d: got ack=%b expected owner %0d", k, ack, own[k]);
            end
            step();
        end
        c_ack = 1'b0;
        #1;
        n_checks++;
        if (spur !== 1'b0) begin
            n_fail++;
            $display("FAIL pushpop_no_spurious: got %b expected 0", spur);
        end
        c_ack = 1'b1;
        step();
        c_ack = 1'b0;
        #1;
        n_checks++;
        if (spur !== 1'b1) begin
            n_fail++;
            $display("FAIL pushpop_count_was_3: got spurious=%b expected 1", spur);
        end
    endtask

    task automatic test_spurious_reset();
        do_reset();
        c_ack = 1'b1;
        #1;
        n_checks++;
        if ({ack, spur} !== 3'b000) begin
            n_fail++;
            $display("FAIL spurious_no_route: got ack=%b spur=%b expected 00/0", ack, spur);
        end
        step();
        c_ack = 1'b0;
        step(); step();
        #1;
        n_checks++;
        if (spur !== 1'b1) begin
            n_fail++;
            $display("FAIL spurious_sticky: got %b expected 1", spur);
        end
        issue(0); issue(1);
        rst = 1'b1; c_ack = 1'b1; c_acc = 1'b1; rd = 2'b11;
        #1;
        n_checks++;
        if ({in_wr, in_rd, acc, ack, err, spur} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_during: got %h expected 0", {in_wr, in_rd, acc, ack, err, spur});
        end
        step();
        rst = 1'b0; idle_inputs();
        #1;
        n_checks++;
        if ({in_wr, in_rd, acc, ack, err, spur} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_after: got %h expected 0", {in_wr, in_rd, acc, ack, err, spur});
        end
        c_ack = 1'b1;
        #1;
        n_checks++;
        if (ack !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_fifo_empty: got ack=%b expected 00", ack);
        end
        step();
        c_ack = 1'b0;
        #1;
        n_checks++;
        if (spur !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_then_spurious: got %b expected 1", spur);
        end
    endtask

    task automatic test_random();
        int   g;
        bit   exp_acc [2];
        bit   exp_ack [2];
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int n = 0; n < 2; n++) begin
                if (!((|wr[n]) || rd[n]) && $urandom_range(0, 2) == 0) begin
                    case ($urandom_range(0, 2))
                        0:       begin rd[n] = 1'b1; wr[n] = 4'h0; end
                        1:       begin rd[n] = 1'b0; wr[n] = 4'($urandom_range(1, 15)); end
                        default: begin rd[n] = 1'b1; wr[n] = 4'($urandom_range(1, 15)); end
                    endcase
                    len[n] = 8'($urandom); addr[n] = $urandom; wdata[n] = $urandom;
                end
            end
            rst     = (cyc == 200);
            c_acc   = ($urandom_range(0, 1) == 1);
            c_ack   = (mq.size() > 0) && ($urandom_range(0, 9) < 4);
            c_err   = ($urandom_range(0, 3) == 0);
            c_rdata = $urandom;
            g = rst ? -1 : mg;
            #1;
            n_checks++;
            if ({in_wr, in_rd} !== ((g < 0) ? 5'b0 : {wr[g], rd[g]})) begin
                n_fail++;
                $display("FAIL random_req_type c%0d: got %h/%b expected grant %0d", cyc, in_wr, in_rd, g);
            end
            if (g >= 0) begin
                n_checks++;
                if ({in_addr, in_len, in_wdata} !== {addr[g], len[g], wdata[g]}) begin
                    n_fail++;
                    $display("FAIL random_req_fields c%0d: got %h %h %h expected %h %h %h", cyc, in_addr, in_len, in_wdata, addr[g], len[g], wdata[g]);
                end
            end
            for (int n = 0; n < 2; n++) begin
                exp_acc[n] = (g == n) && c_acc;
                exp_ack[n] = !rst && c_ack && (mq.size() > 0) && (mq[0] == n);
                n_checks++;
                if ({acc[n], ack[n], err[n]} !== {exp_acc[n], exp_ack[n], exp_ack[n] && c_err}) begin
                    n_fail++;
                    $display("FAIL random_resp%0d c%0d: got acc/ack/err=%b%b%b expected %b%b%b", n, cyc, acc[n], ack[n], err[n], exp_acc[n], exp_ack[n], exp_ack[n] && c_err);
                end
                if (exp_ack[n]) begin
                    n_checks++;
                    if (rdata[n] !== c_rdata) begin
                        n_fail++;
                        $display("FAIL random_rdata%0d c%0d: got %h expected %h", n, cyc, rdata[n], c_rdata);
                    end
                end
            end
            n_checks++;
            if (spur !== (rst ? 1'b0 : ms)) begin
                n_fail++;
                $display("FAIL random_spurious c%0d: got %b expected %b", cyc, spur, ms);
            end
            step();
            for (int n = 0; n < 2; n++) begin
                if (exp_acc[n]) begin
                    wr[n] = 4'h0; rd[n] = 1'b0;
                end
            end
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_single_read();
        test_contention();
        test_backpressure();
        test_ordering();
        test_push_pop();
        test_spurious_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
